// File: rtl/std_maskreg_pkg.sv
// Shared definitions for the masked shared-register arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: operation encodings carried on req_op, FSM state encoding.
package std_maskreg_pkg;

    // Per-requester operation encoding (2 bits each on req_op).
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    // Arbitration state: open round-robin, or pinned to a lock owner.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/std_dffber.sv
// Bit-enable register with synchronous active-high reset to a parameterised value.
// Latency: 1 cycle from en/d to q.
// Backpressure: none; bits with en=0 hold their value.
//
// Ports: clk, reset (sync, active-high), en[WIDTH] per-bit load enable,
//        d[WIDTH] load data, q[WIDTH] stored value.
module std_dffber #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = (en & d) | (~en & q_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/std_rr_arb.sv
// Round-robin grant selection with an override that pins the grant to one index.
// Latency: purely combinational.
// Backpressure: grant is only a selection; the caller qualifies it with valid.
//
// Ports: valid[NUM_REQ] requests, ptr highest-priority index, force_en/force_idx
//        override, grant[NUM_REQ] one-hot (or zero), grant_idx binary index.
module std_rr_arb #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               force_en,
    input  logic [IDX_W-1:0]   force_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cidx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cidx      = '0;
        if (force_en) begin
            // Locked: the owner's slot is offered whether or not it is asking.
            grant[force_idx] = 1'b1;
            grant_idx        = force_idx;
        end else begin
            // Scan upward from ptr with wrap-around; first valid wins.
            for (int i = 0; i < NUM_REQ; i++) begin
                cidx = IDX_W'((int'(ptr) + i) % NUM_REQ);
                if (!found && valid[cidx]) begin
                    found       = 1'b1;
                    grant[cidx] = 1'b1;
                    grant_idx   = cidx;
                end
            end
        end
    end

endmodule

// File: rtl/std_maskreg_arb.sv
// Shared bit-enable register updated by NUM_REQ requesters via masked write/set/clear/read.
// Latency: handshake in cycle N -> q updated and resp_valid/resp_old presented in cycle N+1.
// Backpressure: req_ready grants one requester per cycle (round-robin, or lock owner only).
//
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_op/req_lock/req_mask/
//        req_data per requester (packed, requester 0 in the LSBs); resp_valid one-hot pulse,
//        resp_old pre-update value; q current register value.
module std_maskreg_arb #(
    parameter int                    NUM_REQ     = 4,
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [2*NUM_REQ-1:0]          req_op,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_mask,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_old,
    output logic [DATA_WIDTH-1:0]         q
);

    import std_maskreg_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]  resp_old_q, resp_old_d;

    logic                   arb_force_en;
    logic [IDX_W-1:0]       arb_force_idx;
    logic [NUM_REQ-1:0]     arb_grant;
    logic [IDX_W-1:0]       arb_idx;

    logic                   fire;
    logic [IDX_W-1:0]       next_ptr;
    logic [1:0]             g_op;
    logic                   g_lock;
    logic [DATA_WIDTH-1:0]  g_mask;
    logic [DATA_WIDTH-1:0]  g_data;
    logic [DATA_WIDTH-1:0]  reg_en;
    logic [DATA_WIDTH-1:0]  reg_d;

    std_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .force_en  (arb_force_en),
        .force_idx (arb_force_idx),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Output process: arbiter control and grant; nothing is granted during reset.
    always_comb begin
        arb_force_en  = (state_q == ST_LOCKED);
        arb_force_idx = owner_q;
        req_ready     = reset ? '0 : arb_grant;
        fire          = |(req_valid & req_ready);
    end

    // Fields of the granted requester.
    always_comb begin
        g_op     = req_op[int'(arb_idx)*2 +: 2];
        g_lock   = req_lock[arb_idx];
        g_mask   = req_mask[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
        g_data   = req_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
        next_ptr = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
    end

    // Op decode: set/clear use data as a second bit-select on top of mask.
    always_comb begin
        reg_en = '0;
        reg_d  = '0;
        if (fire) begin
            case (g_op)
                OP_WRITE: begin reg_en = g_mask;          reg_d = g_data; end
                OP_SET:   begin reg_en = g_mask & g_data; reg_d = '1;     end
                OP_CLEAR: begin reg_en = g_mask & g_data; reg_d = '0;     end
                default:  begin reg_en = '0;              reg_d = '0;     end
            endcase
        end
    end

    // Next-state process: lock tracking and round-robin pointer.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = '0;
        resp_old_d   = resp_old_q;
        if (fire) begin
            resp_valid_d = req_valid & req_ready;
            resp_old_d   = q;
            if (g_lock) begin
                state_d = ST_LOCKED;
                owner_d = arb_idx;
                // Pointer only moves on the grant that opens a lock, never inside it.
                if (state_q == ST_IDLE) begin
                    rr_ptr_d = next_ptr;
                end
            end else begin
                state_d  = ST_IDLE;
                rr_ptr_d = next_ptr;
            end
        end
    end

    // State register process.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            resp_valid_q <= '0;
            resp_old_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_old_q   <= resp_old_d;
        end
    end

    std_dffber #(
        .WIDTH       (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (reg_en),
        .d     (reg_d),
        .q     (q)
    );

    assign resp_valid = resp_valid_q;
    assign resp_old   = resp_old_q;

endmodule

// File: doc/std_maskreg_arb.md
Name: std_maskreg_arb

Overview:
- Shares one bit-enable, synchronously reset state register among NUM_REQ requesters, such as CSR-style status/control bits that several pipeline units update.
- Arbitrates requesters round-robin and supports one masked operation per cycle: write, set, clear or read.
- Returns each granted requester the pre-update register value.
- Supports an atomic lock so that one requester can issue a back-to-back sequence without interleaving.

Parameters:
- NUM_REQ, default 4: number of requesters (2..8).
- DATA_WIDTH, default 64: register width in bits.
- RESET_VALUE, default all-zero: register value after reset, [DATA_WIDTH-1:0].

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  grant; handshake fires when valid&ready.
- req_op  in  2*NUM_REQ  per requester: 00 write, 01 set, 10 clear, 11 read.
- req_lock  in  NUM_REQ  keep the grant after this transfer.
- req_mask  in  NUM_REQ*DATA_WIDTH  per-requester bit mask.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester data.
- resp_valid  out  NUM_REQ  one-cycle pulse to the requester served in the previous cycle.
- resp_old  out  DATA_WIDTH  register value before the served operation.
- q  out  DATA_WIDTH  current register value.

Behaviour:
- Reset (synchronous, any cycle, including while LOCKED):
  - q <= RESET_VALUE.
  - resp_valid <= 0; resp_old <= 0.
  - rr_ptr <= 0; state <= IDLE.
  - req_ready stays 0 during the reset cycle.
- Register storage: DATA_WIDTH bit-enable flops driven by en[DATA_WIDTH] and d[DATA_WIDTH]. The standard std_dffber primitive is used, with RESET_VALUE passed through.
- Op decode for granted requester g (all applied at the edge ending the handshake cycle):
  - write: en = mask; d = data.
  - set: en = mask & data; d = all-ones.
  - clear: en = mask & data; d = all-zero.
  - read: en = 0.
  - No handshake: en = 0 and the register holds.
- Latency: handshake in cycle N -> q updated and resp_valid[g]=1 with resp_old = q(N) in cycle N+1. Throughput is one operation per cycle, and back-to-back grants are allowed.
- Arbitration, state IDLE:
  - req_ready is one-hot, or zero if no requester is valid.
  - Winner is the first valid requester scanning from rr_ptr upward, with wrap-around modulo NUM_REQ.
  - req_ready is combinational from req_valid and state.
  - After a grant to g, rr_ptr <= (g+1) mod NUM_REQ.
- Lock, state LOCKED(owner):
  - If the granted transfer has req_lock[g]=1, state <= LOCKED with owner=g.
  - In LOCKED, req_ready = (1 << owner) only; all other requesters are stalled.
  - A transfer from owner with req_lock=0 returns state to IDLE next cycle.
  - If owner drops req_valid, the lock is held and no grant is issued. Liveness is the owner's responsibility.
  - rr_ptr is not advanced while LOCKED; it updates when the unlock transfer fires.
- Invalid ops: none exist; all 4 encodings are defined.
- Mask of zero: a legal no-op write. It still produces a response.
- q is exactly the storage output, with no bypass. A requester observing q in the handshake cycle sees the old value.

Decomposition:
- Package std_maskreg_pkg:
  - op localparams OP_WRITE=2'b00, OP_SET=2'b01, OP_CLEAR=2'b10, OP_READ=2'b11.
  - state encoding ST_IDLE, ST_LOCKED.
- Sub-module std_rr_arb (NUM_REQ):
  - inputs: valid vector, pointer, force_en, force_idx.
  - outputs: one-hot grant and grant index.
  - purely combinational.
- Top keeps: FSM, rr_ptr, op decode, response register, std_dffber instance.

Test Plan:
1. Reset, then idle -> q=RESET_VALUE (e.g. 64'hA5); req_ready=0 for all requesters; resp_valid=0.
2. Req0 write mask=64'hFF, data=64'h3C -> q=64'h..3C in low byte one cycle later; resp_valid[0]=1; resp_old=64'hA5.
3. Req1 set data=64'h100, mask=all-ones, then req2 clear data=64'h1, back-to-back -> bit8 set, then bit0 cleared; responses pulse to 1 then 2 on consecutive cycles.
4. All four requesters valid continuously with reads, rr_ptr=0 -> grant order 0,1,2,3,0, one per cycle.
5. Req2 issues 3 ops with req_lock=1,1,0 while req0/req1 are valid -> only req2 is granted for 3 cycles; then req3→0 scan resumes from rr_ptr=3.
6. Reset asserted in LOCKED state with a pending response -> next cycle state IDLE; resp_valid=0; q=RESET_VALUE; arbitration restarts from requester 0.
